// File: rtl/spram_arb_pkg.sv
// Shared types and constants for the SPRAM video/CPU arbiter.
package spram_arb_pkg;

    typedef enum logic [1:0] {
        LAST_NONE = 2'd0,
        LAST_VID  = 2'd1,
        LAST_CPU  = 2'd2
    } last_e;

    localparam logic [3:0] MASK_LO = 4'b0011;
    localparam logic [3:0] MASK_HI = 4'b1100;

endpackage

// File: rtl/spram_byte_lane.sv
// Byte-lane packing of CPU writes onto the 16-bit SPRAM word and lane selection on reads.
module spram_byte_lane
    import spram_arb_pkg::*;
(
    input  logic        byte_sel,
    input  logic [7:0]  wdata,
    output logic [3:0]  mask,
    output logic [15:0] din,
    input  logic        rd_sel,
    input  logic [15:0] dout,
    output logic [7:0]  rdata
);

    always_comb begin
        mask  = byte_sel ? MASK_HI : MASK_LO;
        din   = {wdata, wdata};
        rdata = rd_sel ? dout[15:8] : dout[7:0];
    end

endmodule

// File: rtl/spram_arbiter.sv
// Single-port RAM arbiter between a video read port and a byte-wide CPU port.
// Define SPRAM_ARB_RR_EN for round-robin arbitration instead of video priority with streak guard.
module spram_arbiter
    import spram_arb_pkg::*;
#(
    parameter int unsigned VID_STREAK_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vid_req,
    input  logic [13:0] vid_addr,
    output logic        vid_ack,
    output logic        vid_rvalid,
    output logic [15:0] vid_rdata,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [14:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic        cpu_rvalid,
    output logic [7:0]  cpu_rdata,
    output logic [13:0] ram_addr,
    output logic [15:0] ram_din,
    output logic [3:0]  ram_mask,
    output logic        ram_wren,
    output logic        ram_cs,
    input  logic [15:0] ram_dout
);

    last_e       last_q;
    logic        grant_vid;
    logic        grant_cpu;
    logic        rd_sel_q;
    logic [3:0]  lane_mask;
    logic [15:0] lane_din;

    spram_byte_lane u_byte_lane (
        .byte_sel (cpu_addr[0]),
        .wdata    (cpu_wdata),
        .mask     (lane_mask),
        .din      (lane_din),
        .rd_sel   (rd_sel_q),
        .dout     (ram_dout),
        .rdata    (cpu_rdata)
    );

    assign vid_rdata = ram_dout;

`ifdef SPRAM_ARB_RR_EN
    always_comb begin
        grant_vid = 1'b0;
        grant_cpu = 1'b0;
        if (vid_req && cpu_req) begin
            grant_cpu = (last_q == LAST_VID);
            grant_vid = !grant_cpu;
        end else begin
            grant_vid = vid_req;
            grant_cpu = cpu_req;
        end
    end
`else
    localparam logic [3:0] STREAK_MAX = 4'(VID_STREAK_MAX);

    logic [3:0] streak_q;

    always_comb begin
        grant_vid = 1'b0;
        grant_cpu = 1'b0;
        if (vid_req && cpu_req) begin
            grant_cpu = (streak_q == STREAK_MAX);
            grant_vid = !grant_cpu;
        end else begin
            grant_vid = vid_req;
            grant_cpu = cpu_req;
        end
    end

    // Counts video grants that made a waiting CPU wait; saturates at the limit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            streak_q <= 4'd0;
        end else if (!cpu_req || grant_cpu) begin
            streak_q <= 4'd0;
        end else if (grant_vid && streak_q != STREAK_MAX) begin
            streak_q <= streak_q + 4'd1;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q     <= LAST_NONE;
            vid_ack    <= 1'b0;
            cpu_ack    <= 1'b0;
            vid_rvalid <= 1'b0;
            cpu_rvalid <= 1'b0;
            rd_sel_q   <= 1'b0;
            ram_cs     <= 1'b0;
            ram_wren   <= 1'b0;
            ram_mask   <= 4'd0;
            ram_addr   <= 14'd0;
            ram_din    <= 16'd0;
        end else begin
            vid_ack    <= grant_vid;
            cpu_ack    <= grant_cpu;
            vid_rvalid <= vid_ack;
            cpu_rvalid <= cpu_ack && !ram_wren;
            // Lane of the command now executing; its data appears next cycle.
            rd_sel_q   <= (ram_mask == MASK_HI);
            if (grant_vid) begin
                last_q   <= LAST_VID;
                ram_cs   <= 1'b1;
                ram_wren <= 1'b0;
                ram_mask <= 4'd0;
                ram_addr <= vid_addr;
            end else if (grant_cpu) begin
                last_q   <= LAST_CPU;
                ram_cs   <= 1'b1;
                ram_wren <= cpu_we;
                ram_mask <= lane_mask;
                ram_addr <= cpu_addr[14:1];
                ram_din  <= lane_din;
            end else begin
                last_q   <= LAST_NONE;
                ram_cs   <= 1'b0;
                ram_wren <= 1'b0;
                ram_mask <= 4'd0;
            end
        end
    end

endmodule
